// File: rtl/mux_skid_stage.sv
// mux_skid_stage: two-entry valid/ready skid stage behind the N-bit 2:1 MUX, registered in_ready, optional flush via MUX_SKID_FLUSH_EN
//   ports: clk, reset (async, active-high), [flush], in_data/in_valid/in_ready (upstream),
//          out_data/out_valid/out_ready (downstream), occupancy (held entries 0..2)
module mux_skid_stage #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         reset,
`ifdef MUX_SKID_FLUSH_EN
  input  logic         flush,
`endif
  input  logic [N-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [N-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [1:0]   occupancy
);
  typedef enum logic [1:0] {EMPTY, BUSY, FULL} state_t;
  state_t     r_state;
  logic [N-1:0] r_main;
  logic [N-1:0] r_skid;
  logic       w_flush;
`ifdef MUX_SKID_FLUSH_EN
  assign w_flush = flush;
`else
  assign w_flush = 1'b0;
`endif
  // in_ready depends on registered state only, never on out_ready
  assign in_ready  = !reset && !w_flush && r_state != FULL;
  assign out_valid = r_state != EMPTY;
  assign out_data  = r_main;
  assign occupancy = r_state == FULL ? 2'd2 : r_state == BUSY ? 2'd1 : 2'd0;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= EMPTY;
      r_main  <= '0;
      r_skid  <= '0;
    end else if (w_flush) begin
      r_state <= EMPTY;
    end else begin
      case (r_state)
        EMPTY: if (in_valid) begin
          r_main  <= in_data;
          r_state <= BUSY;
        end
        BUSY: if (in_valid && out_ready) begin
          r_main  <= in_data;
        end else if (in_valid) begin
          r_skid  <= in_data;
          r_state <= FULL;
        end else if (out_ready) begin
          r_state <= EMPTY;
        end
        FULL: if (out_ready) begin
          r_main  <= r_skid;
          r_state <= BUSY;
        end
        default: r_state <= EMPTY;
      endcase
    end
  end
endmodule

// File: tb/tb_mux_skid_stage.sv
// tb_mux_skid_stage: randomized and directed checks of mux_skid_stage against a queue model
module tb_mux_skid_stage;
  localparam int N = 4;
  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [N-1:0] in_data = '0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [N-1:0] out_data;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [1:0]   occupancy;
`ifdef MUX_SKID_FLUSH_EN
  logic         flush = 1'b0;
`endif
  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;
  bit [N-1:0] q[$];

  mux_skid_stage #(.N(N)) dut (
    .clk(clk),
    .reset(reset),
`ifdef MUX_SKID_FLUSH_EN
    .flush(flush),
`endif
    .in_data(in_data),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .out_data(out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit flushing();
`ifdef MUX_SKID_FLUSH_EN
    return flush;
`else
    return 1'b0;
`endif
  endfunction

  // model: a FIFO of at most two entries; accept only while fewer than two are held
  always @(posedge clk or posedge reset) begin
    if (reset) q.delete();
    else if (flushing()) q.delete();
    else begin
      automatic bit pop  = q.size() > 0 && out_ready;
      automatic bit push = in_valid && q.size() < 2;
      if (pop) void'(q.pop_front());
      if (push) q.push_back(in_data);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("in_ready", in_ready, !reset && !flushing() && q.size() < 2);
      chk("out_valid", out_valid, q.size() > 0);
      chk("occupancy", occupancy, q.size());
      if (q.size() > 0) chk("out_data", out_data, q[0]);
    end
  end

  task automatic cyc(input logic iv, input logic [N-1:0] d, input logic ordy);
    in_valid = iv;
    in_data = d;
    out_ready = ordy;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    in_valid = 1'b1;
    in_data = 4'hF;
    chk_en = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst in_ready", in_ready, 0);
    chk("rst out_valid", out_valid, 0);
    chk("rst occupancy", occupancy, 0);
    chk("rst out_data", out_data, 0);
    reset = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("post-rst in_ready", in_ready, 1);
    cyc(1, 4'h1, 1); chk("stream d1", out_data, 4'h1); chk("stream occ1", occupancy, 1);
    cyc(1, 4'h2, 1); chk("stream d2", out_data, 4'h2); chk("stream occ2", occupancy, 1);
    cyc(1, 4'h3, 1); chk("stream d3", out_data, 4'h3); chk("stream occ3", occupancy, 1);
    cyc(0, 4'h0, 1); chk("stream drained", out_valid, 0);
    cyc(1, 4'hA, 0); chk("stall occ1", occupancy, 1);
    cyc(1, 4'hB, 0); chk("stall occ2", occupancy, 2);
    chk("stall in_ready", in_ready, 0); chk("stall data A", out_data, 4'hA);
    cyc(1, 4'hC, 0); chk("stall hold A", out_data, 4'hA); chk("stall hold occ", occupancy, 2);
    cyc(0, 4'h0, 1); chk("drain B", out_data, 4'hB); chk("drain occ", occupancy, 1);
    cyc(0, 4'h0, 1); chk("drain empty", out_valid, 0);
    cyc(1, 4'h5, 0);
    cyc(1, 4'h6, 0); chk("pre-reset occ", occupancy, 2);
    #2 reset = 1'b1;
    #1;
    chk("async out_valid", out_valid, 0);
    chk("async occupancy", occupancy, 0);
    @(posedge clk);
    #1 reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc(0, 4'h0, 1);
      chk("post-async empty", out_valid, 0);
    end
`ifdef MUX_SKID_FLUSH_EN
    cyc(1, 4'h7, 0);
    cyc(1, 4'h8, 0); chk("pre-flush occ", occupancy, 2);
    flush = 1'b1;
    in_valid = 1'b1;
    in_data = 4'h9;
    #1 chk("flush in_ready", in_ready, 0);
    @(posedge clk);
    #1 flush = 1'b0;
    in_valid = 1'b0;
    chk("flush occupancy", occupancy, 0);
    chk("flush out_valid", out_valid, 0);
`endif
    repeat (1000) begin
      in_valid = 1'($urandom_range(0, 1));
      in_data = N'($urandom);
      out_ready = 1'($urandom_range(0, 3) != 0 || $urandom_range(0, 1) == 0);
      @(posedge clk);
      #1;
    end
    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
